// File: rtl/fc_par_mvm_pkg.sv
// Shared types and helpers for the lane-parallel fully connected engine.
package fc_pkg;

    typedef enum logic [1:0] {LOAD_X, COMPUTE, FLUSH, OUTPUT} state_t;

    localparam int SAT_IW = 128;
    localparam int SAT_OW = 64;

    // Clamp a sign-extended accumulator to the signed t-bit range; caller narrows the result to t bits.
    function automatic logic [SAT_OW-1:0] sat_t(input logic signed [SAT_IW-1:0] v, input int t);
        logic signed [SAT_IW-1:0] hi;
        logic signed [SAT_IW-1:0] lo;
        hi = $signed((SAT_IW'(1) << (t - 1)) - SAT_IW'(1));
        lo = ~hi;
        if (v > hi)
            return hi[SAT_OW-1:0];
        else if (v < lo)
            return lo[SAT_OW-1:0];
        else
            return v[SAT_OW-1:0];
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One MAC lane: full-precision signed product accumulated into a wide register.
module fc_mac_lane #(
    parameter int T     = 16,
    parameter int N     = 8,
    localparam int AccW = 2 * T + $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            en,
    input  logic [T-1:0]    x,
    input  logic [T-1:0]    w,
    output logic [AccW-1:0] acc
);

    logic signed [2*T-1:0] prod;

    assign prod = $signed(x) * $signed(w);

    always_ff @(posedge clk) begin
        if (reset || clear)
            acc <= '0;
        else if (en)
            acc <= acc + {{(AccW - 2 * T){prod[2*T-1]}}, prod};
    end

endmodule

// File: rtl/fc_spram.sv
// Single-port synchronous RAM, one-cycle read latency, read-before-write.
module fc_spram #(
    parameter int T    = 16,
    parameter int SIZE = 8,
    localparam int AW  = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [T-1:0]  wdata,
    output logic [T-1:0]  rdata
);

    logic [T-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/fc_par_mvm.sv
// Fully connected layer y = W*x with P parallel MAC lanes and saturated output.
// Define FC_PAR_RELU_EN to clamp negative outputs to zero.
module fc_par_mvm
    import fc_pkg::*;
#(
    parameter int T     = 16,
    parameter int M     = 8,
    parameter int N     = 8,
    parameter int P     = 2,
    localparam int G    = M / P,
    localparam int AW   = $clog2(G * N),
    localparam int AccW = 2 * T + $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [T-1:0]   input_data,
    input  logic           input_valid,
    output logic           input_ready,
    output logic [AW-1:0]  w_addr,
    input  logic [P*T-1:0] w_data,
    output logic [T-1:0]   output_data,
    output logic           output_valid,
    input  logic           output_ready
);

    localparam int KW = $clog2(N);
    localparam int LW = (P > 1) ? $clog2(P) : 1;
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    state_t                 state;
    logic [KW-1:0]          k, c;
    logic [GW-1:0]          g;
    logic [LW-1:0]          l;
    logic                   vld_pipe;
    logic                   in_hs, out_hs, clear;
    logic                   last_x, last_c, last_l, last_g;
    logic [T-1:0]           x_rd;
    logic [P-1:0][AccW-1:0] acc;
    logic [AccW-1:0]        acc_sel;
    logic [T-1:0]           y_sat, y_val;

    assign input_ready = (state == LOAD_X);
    assign in_hs       = input_valid && input_ready;
    assign out_hs      = output_valid && output_ready;
    assign last_x      = (k == KW'(N - 1));
    assign last_c      = (c == KW'(N - 1));
    assign last_l      = (l == LW'(P - 1));
    assign last_g      = (g == GW'(G - 1));
    assign clear       = (in_hs && last_x) || (out_hs && last_l && !last_g);
    assign w_addr      = AW'(int'(g) * N + int'(c));

    fc_spram #(.T(T), .SIZE(N)) u_xbuf (
        .clk   (clk),
        .we    (in_hs),
        .addr  ((state == LOAD_X) ? k : c),
        .wdata (input_data),
        .rdata (x_rd)
    );

    // Both RAM reads land one cycle after the COMPUTE address, so accumulation trails by one.
    always_ff @(posedge clk) begin
        if (reset)
            vld_pipe <= 1'b0;
        else
            vld_pipe <= (state == COMPUTE);
    end

    for (genvar p = 0; p < P; p++) begin : g_lane
        fc_mac_lane #(.T(T), .N(N)) u_lane (
            .clk   (clk),
            .reset (reset),
            .clear (clear),
            .en    (vld_pipe),
            .x     (x_rd),
            .w     (w_data[p*T +: T]),
            .acc   (acc[p])
        );
    end

    assign acc_sel = acc[l];
    assign y_sat   = T'(sat_t({{(SAT_IW - AccW){acc_sel[AccW-1]}}, acc_sel}, T));

`ifdef FC_PAR_RELU_EN
    assign y_val = y_sat[T-1] ? '0 : y_sat;
`else
    assign y_val = y_sat;
`endif

    assign output_data = output_valid ? y_val : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LOAD_X;
            k            <= '0;
            c            <= '0;
            g            <= '0;
            l            <= '0;
            output_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_X: begin
                    if (in_hs) begin
                        if (last_x) begin
                            k     <= '0;
                            c     <= '0;
                            g     <= '0;
                            state <= COMPUTE;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (last_c) begin
                        c     <= '0;
                        state <= FLUSH;
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                FLUSH: begin
                    l            <= '0;
                    output_valid <= 1'b1;
                    state        <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_hs) begin
                        if (last_l) begin
                            l            <= '0;
                            output_valid <= 1'b0;
                            if (!last_g) begin
                                g     <= g + 1'b1;
                                state <= COMPUTE;
                            end else begin
                                k     <= '0;
                                state <= LOAD_X;
                            end
                        end else begin
                            l <= l + 1'b1;
                        end
                    end
                end
                default: state <= LOAD_X;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_par_mvm.sv
// Bench for fc_par_mvm (T=16, M=4, N=4, P=2): directed table plus random vectors vs. a dot-product model.
module tb_fc_par_mvm;

    localparam int T  = 16;
    localparam int M  = 4;
    localparam int N  = 4;
    localparam int P  = 2;
    localparam int G  = M / P;
    localparam int AW = $clog2(G * N);

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [T-1:0]   input_data;
    logic           input_valid;
    logic           input_ready;
    logic [AW-1:0]  w_addr;
    logic [P*T-1:0] w_data;
    logic [T-1:0]   output_data;
    logic           output_valid;
    logic           output_ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wmem [M][N];

    typedef struct {
        int x [N];
        int w [M][N];
        int y [M];
        bit gaps;
        bit bp;
    } vec_t;

    fc_par_mvm #(.T(T), .M(M), .N(N), .P(P)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_data   (input_data),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .output_data  (output_data),
        .output_valid (output_valid),
        .output_ready (output_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight RAM: address g*N+c holds column c of rows g*P .. g*P+P-1.
    function automatic logic [P*T-1:0] word_at(input logic [AW-1:0] a);
        logic [P*T-1:0] wd;
        int ai;
        ai = int'(a);
        for (int p = 0; p < P; p++)
            wd[p*T +: T] = T'(wmem[(ai / N) * P + p][ai % N]);
        return wd;
    endfunction

    always @(posedge clk) w_data <= word_at(w_addr);

    function automatic vec_t with_ref(input vec_t v);
        longint s;
        for (int r = 0; r < M; r++) begin
            s = 0;
            for (int j = 0; j < N; j++)
                s += longint'(v.x[j]) * longint'(v.w[r][j]);
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
`ifdef FC_PAR_RELU_EN
            if (s < 0) s = 0;
`endif
            v.y[r] = int'(s);
        end
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    task automatic send_x(input int xs[N], input bit gaps, output int acc_edge);
        int n;
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                input_valid = 1'b0;
                @(negedge clk);
            end
            input_valid = 1'b1;
            input_data  = T'(xs[i]);
            n = 0;
            while (!input_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) timeout("x_accept");
            @(negedge clk);
        end
        acc_edge    = cyc;
        input_valid = 1'b0;
        input_data  = '0;
    endtask

    task automatic recv(input vec_t v, input int n_out, output int hs_edge);
        int n;
        logic [T-1:0] held;
        hs_edge = cyc;
        for (int i = 0; i < n_out; i++) begin
            output_ready = !(v.bp && i == 0);
            n = 0;
            while (!output_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) begin
                timeout("y_valid");
                output_ready = 1'b1;
                return;
            end
            if (v.bp && i == 0) begin
                held = output_data;
                for (int b = 0; b < 5; b++) begin
                    @(negedge clk);
                    chk("bp_valid", int'(output_valid), 1);
                    chk("bp_stable", int'(output_data), int'(held));
                end
                output_ready = 1'b1;
            end
            chk($sformatf("y[%0d]", i), int'($signed(output_data)), v.y[i]);
            chk("ready_low_in_output", int'(input_ready), 0);
            @(negedge clk);
            hs_edge = cyc;
        end
        output_ready = 1'b1;
    endtask

    initial begin
        vec_t tbl[$];
        vec_t b, v;
        int a_e, h_e;

        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t b, v;
        int a_e, h_e;

        input_valid  = 1'b0;
        input_data   = '0;
        output_ready = 1'b1;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_output_valid", int'(output_valid), 0);
        chk("rst_output_data", int'(output_data), 0);
        chk("rst_w_addr", int'(w_addr), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_input_ready", int'(input_ready), 1);

        b.x    = '{1, 2, 3, 4};
        b.w    = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}, '{1, 1, 1, 1}, '{-1, -1, -1, -1}};
`ifdef FC_PAR_RELU_EN
        b.y    = '{1, 2, 10, 0};
`else
        b.y    = '{1, 2, 10, -10};
`endif
        b.gaps = 1'b0;
        b.bp   = 1'b0;
        tbl.push_back(b);
        v = b; v.gaps = 1'b1; tbl.push_back(v);
        v = b; v.bp   = 1'b1; tbl.push_back(v);

        v = b;
        for (int r = 0; r < M; r++) begin
            v.x[r % N] = 32767;
            for (int j = 0; j < N; j++) v.w[r][j] = 32767;
            v.y[r] = 32767;
        end
        tbl.push_back(v);
        for (int r = 0; r < M; r++) begin
            for (int j = 0; j < N; j++) v.w[r][j] = -32768;
`ifdef FC_PAR_RELU_EN
            v.y[r] = 0;
`else
            v.y[r] = -32768;
`endif
        end
        tbl.push_back(v);

        for (int t = 0; t < 4; t++) begin
            v = b;
            for (int j = 0; j < N; j++)
                v.x[j] = (t < 2) ? int'($urandom_range(200)) - 100 : int'($urandom_range(65535)) - 32768;
            for (int r = 0; r < M; r++)
                for (int j = 0; j < N; j++)
                    v.w[r][j] = (t < 2) ? int'($urandom_range(200)) - 100 : int'($urandom_range(65535)) - 32768;
            tbl.push_back(with_ref(v));
        end

        foreach (tbl[i]) begin
            wmem = tbl[i].w;
            send_x(tbl[i].x, tbl[i].gaps, a_e);
            if (tbl[i].gaps) chk("ready_low_after_load", int'(input_ready), 0);
            recv(tbl[i], M, h_e);
            if (i == 0) chk("drain_latency", h_e - a_e, G * (N + 1 + P));
        end

        // Abort in group 1, then a fresh vector must come out clean.
        v = b;
        v.x = '{7, -3, 5, 9};
        v = with_ref(v);
        wmem = b.w;
        send_x(v.x, 1'b0, a_e);
        recv(v, P, h_e);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_output_valid", int'(output_valid), 0);
        chk("abort_output_data", int'(output_data), 0);
        chk("abort_input_ready", int'(input_ready), 1);
        send_x(b.x, 1'b0, a_e);
        recv(b, M, h_e);
        chk("post_abort_latency", h_e - a_e, G * (N + 1 + P));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
